// File: rtl/ghash_stream.sv
// ghash_stream: streaming digit-serial GHASH and GCM tag engine (DIGIT_W bits of X per cycle).
// Defining GHASH_TAG_CHECK_EN adds the received-tag register and comparator behind oAuthentic.
module ghash_stream #(
  parameter int DIGIT_W = 8,
  parameter int LEN_W   = 36
) (
  input  logic         iClk,
  input  logic         iRstn,
  input  logic         iStart,
  input  logic [0:127] iHashKey,
  input  logic [0:127] iEky0,
  input  logic         iEky0_valid,
  input  logic [0:127] iData,
  input  logic [4:0]   iDataBytes,
  input  logic         iDataIsAad,
  input  logic         iDataLast,
  input  logic         iData_valid,
  output logic         oData_ready,
  input  logic [0:127] iTag,
  input  logic         iTag_valid,
  output logic [0:127] oTag,
  output logic         oTag_valid,
  output logic         oAuthentic,
  output logic         oError,
  output logic         oBusy
);

  localparam int N = 128 / DIGIT_W;
  localparam logic [0:127] R_POLY = {8'hE1, 120'd0};

  typedef enum logic [2:0] {IDLE, ACCEPT, MULT, LENBLK, FINAL, DONE} state_t;

  state_t state, state_n;

  logic [0:127]     h, x, z, v, y, eky, tag_q;
  logic [LEN_W-1:0] len_a, len_c;
  logic [7:0]       cnt;
  logic             aad_closed, last_q, eky_flag, err_q;

  logic         hs, bad_len, bad_order, empty_last, do_mult, mult_done;
  logic [7:0]   bit_cnt;
  logic [0:127] data_mask, masked, len_block;
  logic [0:127] z_n, v_n, x_n;

  assign hs         = (state == ACCEPT) & iData_valid & ~iStart;
  assign bad_len    = iDataBytes > 5'd16;
  assign bad_order  = iDataIsAad & aad_closed;
  assign empty_last = (iDataBytes == 5'd0) & iDataLast & ~bad_order;
  assign do_mult    = (iDataBytes != 5'd0) & ~bad_len & ~bad_order;
  assign mult_done  = (cnt == 8'(N - 1));

  // Byte 0 sits at bits [0:7], so keeping the first bit_cnt bits keeps the valid bytes.
  assign bit_cnt   = {iDataBytes, 3'b000};
  assign data_mask = ~({128{1'b1}} >> bit_cnt);
  assign masked    = iData & data_mask;
  assign len_block = {64'(len_a), 64'(len_c)};
  assign x_n       = x << DIGIT_W;

  // One digit of the right-shift GF(2^128) multiply: X is consumed MSB-first from bit 0.
  always_comb begin
    z_n = z;
    v_n = v;
    for (int i = 0; i < DIGIT_W; i++) begin
      if (x[i]) z_n = z_n ^ v_n;
      v_n = (v_n >> 1) ^ (v_n[127] ? R_POLY : 128'd0);
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRstn) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ACCEPT: begin
        if (hs && do_mult)         state_n = MULT;
        else if (hs && empty_last) state_n = LENBLK;
      end
      MULT:    if (mult_done) state_n = last_q ? LENBLK : ACCEPT;
      LENBLK:  if (mult_done) state_n = FINAL;
      FINAL:   if (eky_flag)  state_n = DONE;
      default: state_n = state;
    endcase
    if (iStart) state_n = ACCEPT;
  end

  always_comb begin
    oData_ready = 1'b0;
    oTag_valid  = 1'b0;
    oBusy       = 1'b0;
    case (state)
      ACCEPT:  begin oData_ready = ~iStart; oBusy = 1'b1; end
      MULT,
      LENBLK,
      FINAL:   oBusy = 1'b1;
      DONE:    oTag_valid = 1'b1;
      default: ;
    endcase
  end

  assign oTag   = tag_q;
  assign oError = err_q;

  always_ff @(posedge iClk) begin
    if (!iRstn) begin
      h          <= '0;
      x          <= '0;
      z          <= '0;
      v          <= '0;
      y          <= '0;
      eky        <= '0;
      tag_q      <= '0;
      len_a      <= '0;
      len_c      <= '0;
      cnt        <= '0;
      aad_closed <= 1'b0;
      last_q     <= 1'b0;
      eky_flag   <= 1'b0;
      err_q      <= 1'b0;
    end else if (iStart) begin
      h          <= iHashKey;
      x          <= '0;
      z          <= '0;
      v          <= '0;
      y          <= '0;
      eky        <= '0;
      tag_q      <= '0;
      len_a      <= '0;
      len_c      <= '0;
      cnt        <= '0;
      aad_closed <= 1'b0;
      last_q     <= 1'b0;
      eky_flag   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= hs & (bad_len | bad_order);
      if (iEky0_valid) begin
        eky      <= iEky0;
        eky_flag <= 1'b1;
      end
      case (state)
        ACCEPT: begin
          if (hs && do_mult) begin
            x      <= y ^ masked;
            z      <= '0;
            v      <= h;
            cnt    <= '0;
            last_q <= iDataLast;
            if (iDataIsAad) begin
              len_a <= len_a + LEN_W'(bit_cnt);
            end else begin
              len_c      <= len_c + LEN_W'(bit_cnt);
              aad_closed <= 1'b1;
            end
          end else if (hs && empty_last) begin
            x   <= y ^ len_block;
            z   <= '0;
            v   <= h;
            cnt <= '0;
          end
        end
        MULT, LENBLK: begin
          z   <= z_n;
          v   <= v_n;
          x   <= x_n;
          cnt <= cnt + 8'd1;
          if (mult_done) begin
            cnt <= '0;
            y   <= z_n;
            // The length block follows the last data block without returning to ACCEPT.
            if (state == MULT && last_q) begin
              x <= z_n ^ len_block;
              z <= '0;
              v <= h;
            end
          end
        end
        FINAL:   if (eky_flag) tag_q <= y ^ eky;
        default: ;
      endcase
    end
  end

`ifdef GHASH_TAG_CHECK_EN
  logic [0:127] rx_tag;
  logic         rx_flag;

  always_ff @(posedge iClk) begin
    if (!iRstn) begin
      rx_tag  <= '0;
      rx_flag <= 1'b0;
    end else if (iStart) begin
      rx_tag  <= '0;
      rx_flag <= 1'b0;
    end else if (iTag_valid) begin
      rx_tag  <= iTag;
      rx_flag <= 1'b1;
    end
  end

  assign oAuthentic = oTag_valid & rx_flag & (rx_tag == tag_q);
`else
  logic unused_tag;
  assign unused_tag = ^{iTag, iTag_valid};
  assign oAuthentic = 1'b0;
`endif

endmodule
